// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// pc_gen : fetch-stage program counter with redirect, trap and boot sequencing
// Revision: 1.0
// ============================================================================
module pc_gen #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0] TRAP_VECTOR  = {{(WIDTH-7){1'b0}}, 7'h40}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic [1:0]       PCsrc,
   input  logic [WIDTH-1:0] ImmOp,
   input  logic [WIDTH-1:0] rs1,
   input  logic             trap,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             pc_valid,
   output logic             misaligned,
   output logic [WIDTH-1:0] epc
);

   localparam logic [WIDTH-1:0] c_four = {{(WIDTH-3){1'b0}}, 3'd4};

   localparam logic [1:0] c_src_seq    = 2'b00;
   localparam logic [1:0] c_src_branch = 2'b01;
   localparam logic [1:0] c_src_jalr   = 2'b10;
   localparam logic [1:0] c_src_ret    = 2'b11;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_TRAP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] w_pc_nxt;
   logic [WIDTH-1:0] r_epc;
   logic [WIDTH-1:0] w_epc_nxt;
   logic             r_valid;
   logic             w_valid_nxt;
   logic             r_mis;
   logic             w_mis_nxt;

   logic [WIDTH-1:0] w_seq_target;
   logic [WIDTH-1:0] w_branch_target;
   logic [WIDTH-1:0] w_jalr_sum;
   logic [WIDTH-1:0] w_jalr_target;
   logic [WIDTH-1:0] w_target;
   logic             w_target_bad;

   assign w_seq_target    = r_pc + c_four;
   assign w_branch_target = r_pc + ImmOp;
   assign w_jalr_sum      = rs1 + ImmOp;
   assign w_jalr_target   = {w_jalr_sum[WIDTH-1:1], 1'b0};

   always_comb begin
      w_target = w_seq_target;
      case (PCsrc)
         c_src_seq:    w_target = w_seq_target;
         c_src_branch: w_target = w_branch_target;
         c_src_jalr:   w_target = w_jalr_target;
         c_src_ret:    w_target = r_epc;
         default:      w_target = w_seq_target;
      endcase
   end

   // Sequential fetch is never checked; only redirects can land off a word boundary.
   assign w_target_bad = (PCsrc != c_src_seq) && (w_target[1:0] != 2'b00);

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_epc_nxt   = r_epc;
      w_valid_nxt = r_valid;
      w_mis_nxt   = 1'b0;
      case (r_state)
         ST_BOOT: begin
            if (!stall) begin
               w_valid_nxt = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // A trap request wins even over a stall; a bad redirect becomes a trap.
            if (trap || (!stall && w_target_bad)) begin
               w_epc_nxt   = r_pc;
               w_pc_nxt    = TRAP_VECTOR;
               w_valid_nxt = 1'b0;
               w_state_nxt = ST_TRAP;
               w_mis_nxt   = !trap;
            end else if (!stall) begin
               w_pc_nxt = w_target;
            end
         end
         ST_TRAP: begin
            if (!stall) begin
               w_valid_nxt = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_BOOT;
            w_pc_nxt    = RESET_VECTOR;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_BOOT;
         r_pc    <= RESET_VECTOR;
         r_epc   <= '0;
         r_valid <= 1'b0;
         r_mis   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_epc   <= w_epc_nxt;
         r_valid <= w_valid_nxt;
         r_mis   <= w_mis_nxt;
      end
   end

   assign pc_out     = r_pc;
   assign pc_plus4   = r_pc + c_four;
   assign pc_valid   = r_valid;
   assign misaligned = r_mis;
   assign epc        = r_epc;

endmodule
`default_nettype wire
